// File: rtl/gps_ser_reader_pkg.sv
// Shared definitions for the GPS serial readout initiator.
// Contents: FSM state encoding, default widths, GET_* op bit indices and a
// helper that returns the snapshot length in bits for a given GPS build.
package gps_ser_reader_pkg;

    localparam int OP_W_DEF    = 8;
    localparam int NBITS_W_DEF = 10;
    localparam int WORD_W_DEF  = 16;

    // Bit positions of the one-hot op byte driven on op_8.
    localparam int GET_CHAN_IQ  = 0;
    localparam int GET_SRQ      = 1;
    localparam int GET_SNAPSHOT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Snapshot = 48 header bits plus one flag bit and the replica bits per channel.
    function automatic int snapshot_nbits(input int v_gps_chans, input int gps_repl_bits);
        return 48 + v_gps_chans * (1 + gps_repl_bits);
    endfunction

endpackage

// File: rtl/gps_ser_pack.sv
// Packing shift register for the GPS serial reader.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   clr           : discard any partial word (start of transfer)
//   shift_en      : a serial bit is sampled this cycle
//   emit          : this cycle's bit completes a word; restart packing
//   bit_in        : sampled serial bit (MSB-first)
//   word_full     : this cycle's bit is the last bit of a full word
//   word_out      : word including this cycle's bit, left-justified
module gps_ser_pack
    import gps_ser_reader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              emit,
    input  logic              bit_in,
    output logic              word_full,
    output logic [WORD_W-1:0] word_out
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sreg_q, sreg_d, sreg_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d, shamt;

    always_comb begin
        sreg_next = {sreg_q[WORD_W-2:0], bit_in};
        word_full = (cnt_q == CNT_W'(WORD_W - 1));
        // cnt_q+1 bits are valid in sreg_next; move the first of them to the MSB.
        shamt     = CNT_W'(WORD_W - 1) - cnt_q;
        word_out  = sreg_next << shamt;

        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clr) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            if (emit) begin
                sreg_d = '0;
                cnt_d  = '0;
            end else begin
                sreg_d = sreg_next;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/gps_ser_reader.sv
// Initiator for the GPS block's bit-serial readout.
// Accepts (op, nbits), pulses rdReg with op on op_8, then one rdBit per bit,
// sampling ser MSB-first and streaming 16-bit words out on a valid/ready port.
// Ports:
//   cmd_valid/cmd_ready/cmd_op/cmd_nbits : command request
//   rdReg/rdBit/op_8/ser                 : GPS block serial interface
//   word_valid/word_ready/word_data/word_last : output word stream
//   busy                                 : transfer in progress
// Optional feature: define GPS_SER_READER_CKSUM_EN to append a 16-bit XOR
// checksum word after the data words (the checksum word carries word_last).
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready=1
// ST_LOAD  | one-cycle rdReg strobe with op on op_8
// ST_SHIFT | rdBit each cycle, ser sampled and packed
// ST_HOLD  | word pending on the output port, shifting paused
// ST_DONE  | one-cycle tail before returning to idle
module gps_ser_reader
    import gps_ser_reader_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int NBITS_W = NBITS_W_DEF,
    parameter int WORD_W  = WORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OP_W-1:0]    cmd_op,
    input  logic [NBITS_W-1:0] cmd_nbits,
    output logic               rdReg,
    output logic               rdBit,
    output logic [OP_W-1:0]    op_8,
    input  logic               ser,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [WORD_W-1:0]  word_data,
    output logic               word_last,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [NBITS_W-1:0] bits_left_q, bits_left_d;
    logic               word_valid_q, word_valid_d;
    logic [WORD_W-1:0]  word_data_q, word_data_d;
    logic               word_last_q, word_last_d;
`ifdef GPS_SER_READER_CKSUM_EN
    logic [WORD_W-1:0]  cksum_q, cksum_d;
    logic               ck_sent_q, ck_sent_d;
`endif

    logic              pack_clr, pack_shift, pack_emit, pack_full, last_bit;
    logic [WORD_W-1:0] pack_word;

    gps_ser_pack #(.WORD_W(WORD_W)) u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pack_clr),
        .shift_en  (pack_shift),
        .emit      (pack_emit),
        .bit_in    (ser),
        .word_full (pack_full),
        .word_out  (pack_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            bits_left_q  <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_last_q  <= 1'b0;
`ifdef GPS_SER_READER_CKSUM_EN
            cksum_q      <= '0;
            ck_sent_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            bits_left_q  <= bits_left_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_last_q  <= word_last_d;
`ifdef GPS_SER_READER_CKSUM_EN
            cksum_q      <= cksum_d;
            ck_sent_q    <= ck_sent_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        bits_left_d  = bits_left_q;
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        word_last_d  = word_last_q;
        pack_clr     = 1'b0;
        pack_shift   = 1'b0;
        pack_emit    = 1'b0;
        last_bit     = (bits_left_q == NBITS_W'(1));
`ifdef GPS_SER_READER_CKSUM_EN
        cksum_d      = cksum_q;
        ck_sent_d    = ck_sent_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    bits_left_d = cmd_nbits;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pack_clr = 1'b1;
`ifdef GPS_SER_READER_CKSUM_EN
                cksum_d   = '0;
                ck_sent_d = 1'b0;
`endif
                if (bits_left_q == '0) begin
`ifdef GPS_SER_READER_CKSUM_EN
                    word_valid_d = 1'b1;
                    word_data_d  = '0;
                    word_last_d  = 1'b1;
                    ck_sent_d    = 1'b1;
                    state_d      = ST_HOLD;
`else
                    state_d      = ST_DONE;
`endif
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                pack_shift  = 1'b1;
                bits_left_d = bits_left_q - NBITS_W'(1);
                if (pack_full || last_bit) begin
                    pack_emit    = 1'b1;
                    word_valid_d = 1'b1;
                    word_data_d  = pack_word;
`ifdef GPS_SER_READER_CKSUM_EN
                    cksum_d      = cksum_q ^ pack_word;
                    word_last_d  = 1'b0;
`else
                    word_last_d  = last_bit;
`endif
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    word_last_d  = 1'b0;
                    if (bits_left_q != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
`ifdef GPS_SER_READER_CKSUM_EN
                        if (!ck_sent_q) begin
                            word_valid_d = 1'b1;
                            word_data_d  = cksum_q;
                            word_last_d  = 1'b1;
                            ck_sent_d    = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        rdReg      = (state_q == ST_LOAD);
        rdBit      = (state_q == ST_SHIFT);
        op_8       = (state_q == ST_LOAD) ? op_q : '0;
        word_valid = word_valid_q;
        word_data  = word_data_q;
        word_last  = word_last_q;
    end

endmodule

// File: tb/tb_gps_ser_reader.sv
module tb_gps_ser_reader;
    import gps_ser_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_op = '0;
    logic [9:0]  cmd_nbits = '0;
    logic        rdReg, rdBit;
    logic [7:0]  op_8;
    logic        ser;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [15:0] word_data;
    logic        word_last;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // GPS block model: loads a 64-bit pattern on rdReg, presents MSB, shifts on rdBit.
    logic [63:0] model_pat = '0;
    logic [63:0] model_sr = '0;
    assign ser = model_sr[63];

    int bit_total = 0, word_total = 0;
    int overlap = 0, rdreg_long = 0, op_leak = 0;
    logic rdreg_prev = 1'b0;

`ifdef GPS_SER_READER_CKSUM_EN
    localparam logic LAST_DATA = 1'b0;
`else
    localparam logic LAST_DATA = 1'b1;
`endif

    gps_ser_reader dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_nbits(cmd_nbits),
        .rdReg(rdReg), .rdBit(rdBit), .op_8(op_8), .ser(ser),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_last(word_last), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdBit) bit_total <= bit_total + 1;
        if (word_valid && word_ready) word_total <= word_total + 1;
        if (rdReg) model_sr <= model_pat;
        else if (rdBit) model_sr <= model_sr << 1;
    end

    always @(negedge clk) begin
        rdreg_prev <= rdReg;
        if (rdReg && rdBit) overlap <= overlap + 1;
        if (rdReg && rdreg_prev) rdreg_long <= rdreg_long + 1;
        if (!rdReg && op_8 != 8'h00) op_leak <= op_leak + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a command; returns at the negedge of the LOAD cycle.
    task automatic issue(input logic [7:0] op, input logic [9:0] nb, input logic [63:0] pat);
        @(negedge clk);
        model_pat = pat;
        cmd_op    = op;
        cmd_nbits = nb;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = '0;
    endtask

    task automatic get_word(input string tag, output logic [15:0] d, output logic l, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!word_valid && n < 100);
        check({tag, " valid"}, {31'd0, word_valid}, 32'd1);
        d = word_data;
        l = word_last;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 100);
        check({tag, " idle"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] d;
        logic        l;
        int          n, b0, w0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst outs", {rdReg, rdBit, op_8, word_valid, word_data, word_last, busy}, 32'd0);
        rst_n = 1'b1;

        // Scenario 1: GET_SRQ, 16 bits of 0xA5C3
        b0 = bit_total;
        issue(8'(1 << GET_SRQ), 10'd16, 64'hA5C3_0000_0000_0000);
        check("s1 rdReg", {31'd0, rdReg}, 32'd1);
        check("s1 op_8", {24'd0, op_8}, 32'h02);
        check("s1 busy/ready", {30'd0, busy, cmd_ready}, 32'b10);
        @(negedge clk);
        check("s1 first rdBit", {30'd0, rdReg, rdBit}, 32'b01);
        get_word("s1 w0", d, l, n);
        check("s1 latency", n, 32'd16);
        check("s1 data", {16'd0, d}, 32'hA5C3);
        check("s1 last", {31'd0, l}, {31'd0, LAST_DATA});
        check("s1 rdBit count", bit_total - b0, 32'd16);
`ifdef GPS_SER_READER_CKSUM_EN
        get_word("s1 ck", d, l, n);
        check("s1 ck data", {16'd0, d}, 32'hA5C3);
        check("s1 ck last", {31'd0, l}, 32'd1);
`endif
        wait_idle("s1");

        // Scenario 2: 20 bits, 0xBEEF then 1011
        b0 = bit_total;
        issue(8'(1 << GET_CHAN_IQ), 10'd20, 64'hBEEF_B000_0000_0000);
        get_word("s2 w0", d, l, n);
        check("s2 w0 data", {16'd0, d}, 32'hBEEF);
        check("s2 w0 last", {31'd0, l}, 32'd0);
        get_word("s2 w1", d, l, n);
        check("s2 w1 data", {16'd0, d}, 32'hB000);
        check("s2 w1 last", {31'd0, l}, {31'd0, LAST_DATA});
`ifdef GPS_SER_READER_CKSUM_EN
        get_word("s2 ck", d, l, n);
        check("s2 ck data", {16'd0, d}, 32'h0EEF);
        check("s2 ck last", {31'd0, l}, 32'd1);
`endif
        wait_idle("s2");
        check("s2 rdBit count", bit_total - b0, 32'd20);

        // Scenario 3: 32 bits with a 5-cycle stall on the first word,
        // plus a command attempt while busy that must be ignored
        b0 = bit_total;
        issue(8'(1 << GET_SRQ), 10'd32, 64'h1234_00FF_0000_0000);
        word_ready = 1'b0;
        get_word("s3 w0", d, l, n);
        n = bit_total;
        cmd_valid = 1'b1;
        cmd_op    = 8'h04;
        cmd_nbits = 10'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s3 stall hold", {15'd0, word_valid, word_data}, {15'd0, 1'b1, 16'h1234});
        end
        check("s3 stall rdBit", bit_total - n, 32'd0);
        check("s3 busy ready", {30'd0, busy, cmd_ready}, 32'b10);
        check("s3 w0 last", {31'd0, word_last}, 32'd0);
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        word_ready = 1'b1;
        get_word("s3 w1", d, l, n);
        check("s3 w1 data", {16'd0, d}, 32'h00FF);
        check("s3 w1 last", {31'd0, l}, {31'd0, LAST_DATA});
`ifdef GPS_SER_READER_CKSUM_EN
        // Scenario 6: checksum word 0x1234 ^ 0x00FF
        get_word("s6 ck", d, l, n);
        check("s6 ck data", {16'd0, d}, 32'h12CB);
        check("s6 ck last", {31'd0, l}, 32'd1);
`endif
        wait_idle("s3");
        check("s3 rdBit count", bit_total - b0, 32'd32);
        @(negedge clk);
        check("s3 no queued cmd", {31'd0, rdReg}, 32'd0);

        // Scenario 4: zero-length read
        b0 = bit_total;
        w0 = word_total;
        issue(8'(1 << GET_SNAPSHOT), 10'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("s4 rdReg op", {23'd0, rdReg, op_8}, {23'd0, 1'b1, 8'h04});
`ifdef GPS_SER_READER_CKSUM_EN
        get_word("s4 ck", d, l, n);
        check("s4 ck data", {16'd0, d}, 32'h0000);
        check("s4 ck last", {31'd0, l}, 32'd1);
        wait_idle("s4");
        check("s4 words", word_total - w0, 32'd1);
`else
        wait_idle("s4");
        check("s4 words", word_total - w0, 32'd0);
`endif
        check("s4 rdBit count", bit_total - b0, 32'd0);

        // Scenario 5: reset after 7 rdBits of a 64-bit snapshot read
        b0 = bit_total;
        issue(8'(1 << GET_SNAPSHOT), 10'(snapshot_nbits(4, 3)), 64'hDEAD_BEEF_CAFE_F00D);
        n = 0;
        while ((bit_total - b0) < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("s5 reached 7 bits", bit_total - b0, 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        check("s5 rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("s5 rst outs", {rdReg, rdBit, op_8, word_valid, word_data, word_last, busy}, 32'd0);
        rst_n = 1'b1;
        issue(8'(1 << GET_SRQ), 10'd16, 64'h5A0F_0000_0000_0000);
        get_word("s5 w0", d, l, n);
        check("s5 data", {16'd0, d}, 32'h5A0F);
        check("s5 last", {31'd0, l}, {31'd0, LAST_DATA});
        wait_idle("s5");

        // Interface invariants over the whole run
        check("inv rdReg&rdBit", overlap, 32'd0);
        check("inv rdReg width", rdreg_long, 32'd0);
        check("inv op_8 leak", op_leak, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
